cdb_arbiter: RTL and testbench

Parametrised common data bus (CDB) for the Tomasulo core. It collects completed results from N_CH functional units, buffers each unit's results in its own FIFO, and picks one per cycle by round-robin. The pick is driven as a registered broadcast (valid, tag, value, source) that reservation stations and the RoB snoop through ports, with no hierarchical writes. It also adds a flush path for misprediction recovery and explicit backpressure to the producers.

---
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Brief   : Common data bus; per-unit result FIFOs, round-robin pick,
//           registered broadcast, flush and producer backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_CH       = 3,
  parameter int TAG_W      = 7,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*TAG_W-1:0]    in_tag,
  input  logic [N_CH*DATA_W-1:0]   in_value,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_value,
  output logic [CH_W-1:0]          cdb_src,
  output logic [N_CH-1:0]          pending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

  logic [TAG_W-1:0]  w_head_tag   [N_CH];
  logic [DATA_W-1:0] w_head_value [N_CH];
  logic [N_CH-1:0]   w_pending;
  logic [N_CH-1:0]   w_pop;
  logic              w_grant_any;
  logic [CH_W-1:0]   w_grant_idx;
  logic [CH_W-1:0]   w_rr_next;
  logic              w_hi_found;
  logic [CH_W-1:0]   w_hi_idx;
  logic [CH_W-1:0]   w_lo_idx;
  logic [CH_W-1:0]   r_rr_ptr;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [TAG_W-1:0]  r_tag_mem   [FIFO_DEPTH];
      logic [DATA_W-1:0] r_value_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  r_wptr;
      logic [PTR_W-1:0]  r_rptr;
      logic [CNT_W-1:0]  r_cnt;
      logic              w_push;

      // Ready comes from registered count only: a full FIFO being popped this
      // cycle still refuses the push.
      assign in_ready[gi]     = (r_cnt != C_FULL);
      assign w_pending[gi]    = (r_cnt != '0);
      assign w_push           = in_valid[gi] & in_ready[gi];
      assign w_pop[gi]        = w_grant_any && (w_grant_idx == CH_W'(gi));
      assign w_head_tag[gi]   = r_tag_mem[r_rptr];
      assign w_head_value[gi] = r_value_mem[r_rptr];

      always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push)
            r_wptr <= r_wptr + PTR_W'(1);
          if (w_pop[gi])
            r_rptr <= r_rptr + PTR_W'(1);
          case ({w_push, w_pop[gi]})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      always_ff @(posedge clock) begin
        if (reset_n && !flush && w_push) begin
          r_tag_mem[r_wptr]   <= in_tag[gi*TAG_W +: TAG_W];
          r_value_mem[r_wptr] <= in_value[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  assign pending = w_pending;

  // Lowest pending channel at or above rr_ptr wins; otherwise wrap to the
  // lowest pending channel overall.
  always_comb begin
    w_grant_any = |w_pending;
    w_hi_found  = 1'b0;
    w_hi_idx    = '0;
    w_lo_idx    = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (w_pending[c]) begin
        w_lo_idx = CH_W'(c);
        if (CH_W'(c) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = CH_W'(c);
        end
      end
    end
    w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    w_rr_next   = (w_grant_idx == CH_W'(N_CH - 1)) ? '0 : w_grant_idx + CH_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rr_ptr  <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= w_grant_any;
      if (w_grant_any) begin
        r_rr_ptr  <= w_rr_next;
        cdb_tag   <= w_head_tag[w_grant_idx];
        cdb_value <= w_head_value[w_grant_idx];
        cdb_src   <= w_grant_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Directed scoreboard bench for cdb_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N_CH       = 3;
  localparam int TAG_W      = 7;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 2;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [N_CH-1:0]        in_valid = '0;
  logic [N_CH-1:0]        in_ready;
  logic [N_CH*TAG_W-1:0]  in_tag = '0;
  logic [N_CH*DATA_W-1:0] in_value = '0;
  logic                   flush = 1'b0;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_value;
  logic [CH_W-1:0]        cdb_src;
  logic [N_CH-1:0]        pending;

  cdb_arbiter #(
    .N_CH(N_CH), .TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_value(in_value), .flush(flush), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src), .pending(pending)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]        ch;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } item_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CH_W-1:0]  src;
    int               cyc;
  } log_t;

  item_t src_q[$];
  item_t sb[$];
  log_t  bc_log[$];
  log_t  acc_log[$];
  int    cnt[N_CH];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string what, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", what, obs, exp);
    end
  endtask

  function automatic int find_src(input int c);
    foreach (src_q[i]) if (src_q[i].ch == 2'(c)) return i;
    return -1;
  endfunction

  function automatic int find_sb(input int c);
    foreach (sb[i]) if (sb[i].ch == 2'(c)) return i;
    return -1;
  endfunction

  function automatic item_t mk(input int c, input int t);
    item_t it;
    it.ch    = 2'(c);
    it.tag   = TAG_W'(t);
    it.value = $urandom;
    return it;
  endfunction

  // One clock: offer each channel's oldest queued item, step the edge, then
  // update the count model and scoreboard from what the DUT shows.
  task automatic step(input bit do_flush = 1'b0, input bit do_rst = 1'b0);
    logic [N_CH-1:0] acc;
    int k;
    for (int c = 0; c < N_CH; c++) begin
      k = find_src(c);
      in_valid[c] = (k >= 0);
      if (k >= 0) begin
        in_tag[c*TAG_W +: TAG_W]    = src_q[k].tag;
        in_value[c*DATA_W +: DATA_W] = src_q[k].value;
      end
    end
    flush   = do_flush;
    reset_n = !do_rst;
    acc = in_valid & in_ready;
    @(posedge clock);
    #1;
    cyc++;
    in_valid = '0;
    flush    = 1'b0;
    reset_n  = 1'b1;
    if (do_flush || do_rst) begin
      sb.delete();
      src_q.delete();
      cnt = '{default: 0};
      chk("clear_valid", 64'(cdb_valid), 64'(0));
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (acc[c]) begin
          k = find_src(c);
          sb.push_back(src_q[k]);
          acc_log.push_back('{tag: src_q[k].tag, src: CH_W'(c), cyc: cyc});
          src_q.delete(k);
          cnt[c]++;
        end
      end
      if (cdb_valid) begin
        chk("src_range", 64'(cdb_src < CH_W'(N_CH)), 64'(1));
        k = find_sb(int'(cdb_src));
        chk("bc_expected", 64'(k >= 0), 64'(1));
        if (k >= 0) begin
          chk("bc_tag", 64'(cdb_tag), 64'(sb[k].tag));
          chk("bc_value", 64'(cdb_value), 64'(sb[k].value));
          sb.delete(k);
          cnt[cdb_src]--;
        end
        bc_log.push_back('{tag: cdb_tag, src: cdb_src, cyc: cyc});
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      chk("in_ready", 64'(in_ready[c]), 64'(cnt[c] != FIFO_DEPTH));
      chk("pending", 64'(pending[c]), 64'(cnt[c] != 0));
    end
  endtask

  initial begin
    int b;
    int n;
    int maxc;
    bit full_seen;
    bit seen7f;
    logic [TAG_W-1:0] rr_tags [6];
    item_t it;
    cnt = '{default: 0};

    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_tag", 64'(cdb_tag), 64'(0));
    chk("rst_value", 64'(cdb_value), 64'(0));
    chk("rst_src", 64'(cdb_src), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(3'b111));

    // Single push on ch1: visible only in the cycle after E+1
    it = mk(1, 'h05);
    it.value = 32'hDEADBEEF;
    src_q.push_back(it);
    step();
    chk("single_lat0", 64'(cdb_valid), 64'(0));
    step();
    chk("single_valid", 64'(cdb_valid), 64'(1));
    chk("single_tag", 64'(cdb_tag), 64'(7'h05));
    chk("single_value", 64'(cdb_value), 64'(32'hDEADBEEF));
    chk("single_src", 64'(cdb_src), 64'(1));
    step();
    chk("single_pulse", 64'(cdb_valid), 64'(0));

    // Round robin from rr_ptr=0
    step(1'b0, 1'b1);
    src_q.push_back(mk(0, 1)); src_q.push_back(mk(0, 2));
    src_q.push_back(mk(1, 3)); src_q.push_back(mk(1, 4));
    src_q.push_back(mk(2, 5)); src_q.push_back(mk(2, 6));
    rr_tags = '{7'd1, 7'd3, 7'd5, 7'd2, 7'd4, 7'd6};
    b = bc_log.size();
    for (int i = 0; i < 9; i++) step();
    chk("rr_count", 64'(bc_log.size() - b), 64'(6));
    if (bc_log.size() - b == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("rr_tag", 64'(bc_log[b+i].tag), 64'(rr_tags[i]));
        chk("rr_src", 64'(bc_log[b+i].src), 64'(i % 3));
        chk("rr_cycle", 64'(bc_log[b+i].cyc - bc_log[b].cyc), 64'(i));
      end
    end

    // Reset mid-stream: third ch0 entry is still buffered at the reset edge
    for (int i = 0; i < 3; i++) src_q.push_back(mk(0, 'h11 + i));
    b = bc_log.size();
    for (int i = 0; i < 3; i++) step();
    step(1'b0, 1'b1);
    chk("mid_rst_pending", 64'(pending), 64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(3'b111));
    for (int i = 0; i < 4; i++) step();
    chk("mid_rst_bc", 64'(bc_log.size() - b), 64'(2));

    // Backpressure: three busy channels drive ch2 into full
    for (int i = 0; i < 10; i++) begin
      src_q.push_back(mk(2, 'h20 + i));
      src_q.push_back(mk(0, 'h40 + i));
      src_q.push_back(mk(1, 'h60 + i));
    end
    b = bc_log.size();
    full_seen = 1'b0;
    for (int i = 0; i < 60 && (src_q.size() != 0 || sb.size() != 0); i++) begin
      step();
      if (in_ready[2] === 1'b0) full_seen = 1'b1;
    end
    chk("bp_full_seen", 64'(full_seen), 64'(1));
    chk("bp_drained", 64'(src_q.size() + sb.size()), 64'(0));
    n = 0;
    for (int i = b; i < bc_log.size(); i++) begin
      if (bc_log[i].src == 2'd2) begin
        chk("bp_order", 64'(bc_log[i].tag), 64'('h20 + n));
        n++;
      end
    end
    chk("bp_ch2_count", 64'(n), 64'(10));

    // Flush with a simultaneous ch2 push
    src_q.push_back(mk(0, 'h31)); src_q.push_back(mk(0, 'h32));
    src_q.push_back(mk(1, 'h33));
    step();
    step();
    src_q.push_back(mk(2, 'h7F));
    b = bc_log.size();
    step(1'b1, 1'b0);
    chk("flush_pending", 64'(pending), 64'(0));
    chk("flush_ready", 64'(in_ready), 64'(3'b111));
    for (int i = 0; i < 4; i++) step();
    seen7f = 1'b0;
    for (int i = b; i < bc_log.size(); i++) if (bc_log[i].tag == 7'h7F) seen7f = 1'b1;
    chk("flush_no_7f", 64'(seen7f), 64'(0));
    chk("flush_no_bc", 64'(bc_log.size() - b), 64'(0));

    // Back-to-back stream on ch0 across two pointer wraps
    for (int i = 0; i < 9; i++) src_q.push_back(mk(0, i));
    b = bc_log.size();
    n = acc_log.size();
    maxc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cnt[0] > maxc) maxc = cnt[0];
    end
    chk("stream_maxcnt", 64'(maxc), 64'(1));
    chk("stream_count", 64'(bc_log.size() - b), 64'(9));
    if (bc_log.size() - b == 9 && acc_log.size() - n == 9) begin
      for (int i = 0; i < 9; i++) begin
        chk("stream_tag", 64'(bc_log[b+i].tag), 64'(i));
        chk("stream_lat", 64'(bc_log[b+i].cyc - acc_log[n+i].cyc), 64'(1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
